debug_loader: RTL and testbench
===============================

DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 The clock and reset ports SHALL be CPU_CLK and CPU_RST; there is one clock, and reset is asynchronous and active-high.
REQ-002 CPU_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 CPU_RST  in  1  async active-high reset of all loader state.
REQ-004 rx_valid  in  1  host byte valid.
REQ-005 rx_data  in  8  host byte.
REQ-006 rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid&rx_ready on a rising edge.
REQ-007 tx_valid  out  1  response byte valid.
REQ-008 tx_data  out  8  response byte.
REQ-009 tx_ready  in  1  host accepts byte; a transfer occurs when tx_valid&tx_ready on a rising edge.
REQ-010 core_rst  out  1  drives the core's CPU_RST input; 1 = core held in reset.
REQ-011 inst_a2 / inst_wd2  out  32 each  instruction-cache debug address / write data.
REQ-012 inst_we2  out  4  instruction-cache debug byte write enables.
REQ-013 data_a2 / data_wd2  out  32 each  data-cache debug address / write data.
REQ-014 data_we2  out  4  data-cache debug byte write enables.
REQ-015 data_rd2 / inst_rd2  in  32 each  cache debug read data, valid one cycle after address is stable.

Function
REQ-016 Frame format SHALL be: 1 command byte, 4 address bytes (little-endian), then 4 data bytes (little-endian) for write commands only.
REQ-017 Commands SHALL be: 0x01 write inst word, 0x02 write data word, 0x03 read data word, 0x04 read inst word, 0x05 run (release core), 0x06 halt (hold core); any other command byte SHALL be discarded, with the loader staying in IDLE.
REQ-018 States SHALL be IDLE, ADDR, DATA, WRITE, READ0, READ1, SEND, with byte counter cnt[1:0].
REQ-019 IDLE: rx_ready=1; commands 0x01-0x04 go to ADDR with cnt=0; 0x05 clears core_rst and 0x06 sets core_rst on the accepting edge.
REQ-020 ADDR: rx_ready=1; each accepted byte fills addr[8*cnt+7:8*cnt]; after the 4th byte, go to DATA for writes or READ0 for reads, with cnt wrapping to 0.
REQ-021 DATA: rx_ready=1; each accepted byte fills wdata likewise; after the 4th byte, go to WRITE.
REQ-022 WRITE: exactly one cycle with the selected cache's a2=addr, wd2=wdata, we2=4'hF, other cache's we2=0; rx_ready=0; next state is IDLE.
REQ-023 READ0: the selected a2=addr and we2=0; READ1 SHALL latch the selected rd2 into rdata at its end; next state is SEND with cnt=0; rx_ready=0 in both states.
REQ-024 SEND: tx_valid=1, tx_data=rdata[8*cnt+7:8*cnt]; cnt advances only on a tx handshake; after the 4th handshake go to IDLE; tx_data SHALL hold stable while tx_ready=0.
REQ-025 rx_ready SHALL be 0 in WRITE, READ0, READ1 and SEND; tx_valid SHALL be 0 outside SEND.
REQ-026 Write and read commands (0x01-0x04) SHALL be accepted only while core_rst=1; if core_rst=0 the command byte is consumed and dropped, keeping the core and loader from contending for cache ports.
REQ-027 a2 outputs SHALL hold their last driven value outside WRITE/READ; we2 SHALL be 0 in every state except WRITE.
REQ-028 Address bits [1:0] SHALL be passed through unmodified; word alignment is the host's responsibility.
REQ-029 No frame timeout; a partially received frame SHALL wait indefinitely for the remaining bytes.

Reset
REQ-030 CPU_RST=1 SHALL immediately force: state=IDLE, cnt=0, addr/wdata/rdata=0, core_rst=1, rx_ready=0 while reset is held, tx_valid=0, all we2=0, all a2/wd2=0.
REQ-031 Reset asserted mid-frame or mid-SEND SHALL abandon the frame with no cache write issued; after release, the next byte is interpreted as a command.

Verification
REQ-032 Reset -> core_rst=1, tx_valid=0, inst_we2=data_we2=0; rx_ready=1 one cycle after release.
REQ-033 Bytes 01, 00,00,00,00, 13,00,00,00 -> exactly one cycle with inst_a2=0x0, inst_wd2=0x00000013, inst_we2=4'hF, data_we2=0.
REQ-034 Write data 0x10=0xDEADBEEF via 0x02, then 03,10,00,00,00 with tx_ready toggling -> tx bytes EF,BE,AD,DE in order, each held until its handshake.
REQ-035 Bytes 05 -> core_rst falls; then 01+8 bytes -> no we2 pulse; then 06 -> core_rst=1.
REQ-036 CPU_RST pulse after the 3rd data byte of a 0x02 frame -> no data_we2 pulse; a fresh complete frame then writes correctly.
REQ-037 Byte 0x7F -> no state change, no cache access; a following valid frame executes normally.

Source files
------------

// File: rtl/debug_loader_if.sv
// ---------------------------------------------------------------------------
// debug_loader_if
// Purpose : byte-stream link between the debug host and the debug loader.
//           The host pushes command/address/data bytes on the rx channel and
//           pulls read-back bytes from the tx channel. Both channels use a
//           valid/ready handshake; a byte moves on a rising clock edge where
//           valid and ready are both high.
// Signals :
//   rx_valid  host -> loader  host byte valid
//   rx_data   host -> loader  host byte
//   rx_ready  loader -> host  loader can take a byte
//   tx_valid  loader -> host  response byte valid
//   tx_data   loader -> host  response byte
//   tx_ready  host -> loader  host can take a byte
// Modports: master = host side, slave = loader side.
// ---------------------------------------------------------------------------
interface debug_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/debug_loader.sv
// ---------------------------------------------------------------------------
// debug_loader
// Purpose : host-driven debug loader for a small CPU. Parses byte frames
//           (command, 4 address bytes LE, 4 data bytes LE for writes) and
//           issues single-word writes/reads on the instruction- and
//           data-cache debug ports, returns read data as 4 bytes LE, and
//           controls the core reset.
// Ports   :
//   CPU_CLK    in   sole clock, rising edge
//   CPU_RST    in   asynchronous active-high reset
//   host       if   byte stream link (slave modport)
//   core_rst   out  1 = core held in reset
//   inst_a2 / inst_wd2 / inst_we2   out  instruction-cache debug port
//   data_a2 / data_wd2 / data_we2   out  data-cache debug port
//   inst_rd2 / data_rd2             in   cache read data, one cycle latency
//
// Commands: 01 write inst, 02 write data, 03 read data, 04 read inst,
//           05 release core, 06 hold core; anything else is dropped.
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR  | collecting 4 address bytes
// DATA  | collecting 4 write-data bytes
// WRITE | one-cycle cache write strobe
// READ0 | address presented to the selected cache
// READ1 | cache read data captured at end of cycle
// SEND  | returning 4 read-data bytes to the host
// ---------------------------------------------------------------------------
module debug_loader (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  debug_loader_if.slave host,
  output logic        core_rst,
  output logic [31:0] inst_a2,
  output logic [31:0] inst_wd2,
  output logic [3:0]  inst_we2,
  output logic [31:0] data_a2,
  output logic [31:0] data_wd2,
  output logic [3:0]  data_we2,
  input  logic [31:0] data_rd2,
  input  logic [31:0] inst_rd2
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    READ0 = 3'd4,
    READ1 = 3'd5,
    SEND  = 3'd6
  } state_t;

  localparam logic [7:0] CMD_WR_INST = 8'h01;
  localparam logic [7:0] CMD_WR_DATA = 8'h02;
  localparam logic [7:0] CMD_RD_DATA = 8'h03;
  localparam logic [7:0] CMD_RD_INST = 8'h04;
  localparam logic [7:0] CMD_RUN     = 8'h05;
  localparam logic [7:0] CMD_HALT    = 8'h06;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_is_write;
  logic        r_sel_inst;
  logic        r_core_rst;
  logic        r_rx_ready;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic [31:0] r_inst_a2;
  logic [31:0] r_inst_wd2;
  logic [3:0]  r_inst_we2;
  logic [31:0] r_data_a2;
  logic [31:0] r_data_wd2;
  logic [3:0]  r_data_we2;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_cmd_mem;
  logic [1:0]  w_cnt_inc;
  logic [31:0] w_addr_full;
  logic [31:0] w_wdata_full;
  logic [31:0] w_rd2_sel;

  assign w_rx_fire    = host.rx_valid & r_rx_ready;
  assign w_tx_fire    = r_tx_valid & host.tx_ready;
  assign w_cmd_mem    = (host.rx_data == CMD_WR_INST) || (host.rx_data == CMD_WR_DATA) ||
                        (host.rx_data == CMD_RD_DATA) || (host.rx_data == CMD_RD_INST);
  assign w_cnt_inc    = r_cnt + 2'd1;
  // Final byte merged in so the cache port sees the full word on the very
  // next edge, without an extra state to settle the assembly register.
  assign w_addr_full  = {host.rx_data, r_addr[23:0]};
  assign w_wdata_full = {host.rx_data, r_wdata[23:0]};
  assign w_rd2_sel    = r_sel_inst ? inst_rd2 : data_rd2;

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_sel_inst <= 1'b0;
      r_core_rst <= 1'b1;
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
      r_inst_a2  <= 32'd0;
      r_inst_wd2 <= 32'd0;
      r_inst_we2 <= 4'd0;
      r_data_a2  <= 32'd0;
      r_data_wd2 <= 32'd0;
      r_data_we2 <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            // Memory commands only while the core is held, so the loader
            // never fights the running core for the cache ports.
            if (w_cmd_mem && r_core_rst) begin
              r_state    <= ADDR;
              r_cnt      <= 2'd0;
              r_is_write <= (host.rx_data == CMD_WR_INST) || (host.rx_data == CMD_WR_DATA);
              r_sel_inst <= (host.rx_data == CMD_WR_INST) || (host.rx_data == CMD_RD_INST);
            end else if (host.rx_data == CMD_RUN) begin
              r_core_rst <= 1'b0;
            end else if (host.rx_data == CMD_HALT) begin
              r_core_rst <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (w_rx_fire) begin
            r_addr[{r_cnt, 3'b000} +: 8] <= host.rx_data;
            r_cnt <= w_cnt_inc;
            if (r_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= DATA;
              end else begin
                r_state    <= READ0;
                r_rx_ready <= 1'b0;
                if (r_sel_inst) r_inst_a2 <= w_addr_full;
                else            r_data_a2 <= w_addr_full;
              end
            end
          end
        end

        DATA: begin
          if (w_rx_fire) begin
            r_wdata[{r_cnt, 3'b000} +: 8] <= host.rx_data;
            r_cnt <= w_cnt_inc;
            if (r_cnt == 2'd3) begin
              r_state    <= WRITE;
              r_rx_ready <= 1'b0;
              if (r_sel_inst) begin
                r_inst_a2  <= r_addr;
                r_inst_wd2 <= w_wdata_full;
                r_inst_we2 <= 4'hF;
              end else begin
                r_data_a2  <= r_addr;
                r_data_wd2 <= w_wdata_full;
                r_data_we2 <= 4'hF;
              end
            end
          end
        end

        WRITE: begin
          r_inst_we2 <= 4'd0;
          r_data_we2 <= 4'd0;
          r_rx_ready <= 1'b1;
          r_state    <= IDLE;
        end

        READ0: begin
          r_state <= READ1;
        end

        READ1: begin
          r_rdata    <= w_rd2_sel;
          r_tx_data  <= w_rd2_sel[7:0];
          r_tx_valid <= 1'b1;
          r_cnt      <= 2'd0;
          r_state    <= SEND;
        end

        SEND: begin
          if (w_tx_fire) begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == 2'd3) begin
              r_tx_valid <= 1'b0;
              r_rx_ready <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_tx_data <= r_rdata[{w_cnt_inc, 3'b000} +: 8];
            end
          end
        end

        default: begin
          r_state    <= IDLE;
          r_cnt      <= 2'd0;
          r_rx_ready <= 1'b0;
          r_tx_valid <= 1'b0;
          r_inst_we2 <= 4'd0;
          r_data_we2 <= 4'd0;
        end
      endcase
    end
  end

  assign host.rx_ready = r_rx_ready;
  assign host.tx_valid = r_tx_valid;
  assign host.tx_data  = r_tx_data;
  assign core_rst      = r_core_rst;
  assign inst_a2       = r_inst_a2;
  assign inst_wd2      = r_inst_wd2;
  assign inst_we2      = r_inst_we2;
  assign data_a2       = r_data_a2;
  assign data_wd2      = r_data_wd2;
  assign data_we2      = r_data_we2;

endmodule

// File: tb/tb_debug_loader.sv
module tb_debug_loader;

  logic        CPU_CLK;
  logic        CPU_RST;
  logic        core_rst;
  logic [31:0] inst_a2, inst_wd2, data_a2, data_wd2;
  logic [3:0]  inst_we2, data_we2;
  logic [31:0] inst_rd2, data_rd2;

  int total = 0;
  int bad   = 0;

  int inst_pulses = 0;
  int data_pulses = 0;
  int cross_errs  = 0;
  logic [31:0] last_inst_a2, last_inst_wd2, last_data_a2, last_data_wd2;

  logic [31:0] inst_mem [16];
  logic [31:0] data_mem [16];

  debug_loader_if bus ();

  debug_loader dut (
    .CPU_CLK (CPU_CLK),
    .CPU_RST (CPU_RST),
    .host    (bus.slave),
    .core_rst(core_rst),
    .inst_a2 (inst_a2),
    .inst_wd2(inst_wd2),
    .inst_we2(inst_we2),
    .data_a2 (data_a2),
    .data_wd2(data_wd2),
    .data_we2(data_we2),
    .data_rd2(data_rd2),
    .inst_rd2(inst_rd2)
  );

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  // Simple cache models: full-word writes, registered read (one-cycle latency).
  always @(posedge CPU_CLK) begin
    if (inst_we2 == 4'hF) inst_mem[inst_a2[5:2]] <= inst_wd2;
    if (data_we2 == 4'hF) data_mem[data_a2[5:2]] <= data_wd2;
    inst_rd2 <= inst_mem[inst_a2[5:2]];
    data_rd2 <= data_mem[data_a2[5:2]];
  end

  // Strobe monitor: counts cycles with a write enable and records the port.
  always @(negedge CPU_CLK) begin
    if (inst_we2 != 4'd0) begin
      inst_pulses   <= inst_pulses + 1;
      last_inst_a2  <= inst_a2;
      last_inst_wd2 <= inst_wd2;
      if (data_we2 != 4'd0 || inst_we2 != 4'hF) cross_errs <= cross_errs + 1;
    end
    if (data_we2 != 4'd0) begin
      data_pulses   <= data_pulses + 1;
      last_data_a2  <= data_a2;
      last_data_wd2 <= data_wd2;
      if (inst_we2 != 4'd0 || data_we2 != 4'hF) cross_errs <= cross_errs + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CPU_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge CPU_CLK);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge CPU_CLK);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic with_data);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (with_data) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
  endtask

  // Receives one byte, stalling the host for two cycles first to check hold.
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    bus.tx_ready = 1'b0;
    while (!bus.tx_valid && n < 50) begin
      @(negedge CPU_CLK);
      n++;
    end
    check({tag, "_valid"}, {31'd0, bus.tx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, bus.tx_data}, {24'd0, exp});
    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    check({tag, "_hold"}, {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, exp});
    bus.tx_ready = 1'b1;
    @(posedge CPU_CLK);
    #1;
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ip, dp;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.tx_ready = 1'b0;
    CPU_RST      = 1'b1;
    tick(3);

    // Reset state
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_we2", {24'd0, inst_we2, data_we2}, 32'd0);
    check("rst_a2", inst_a2 | data_a2, 32'd0);
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    #1;
    check("rel_rx_ready_before_edge", {31'd0, bus.rx_ready}, 32'd0);
    tick(1);
    check("rel_rx_ready_after_edge", {31'd0, bus.rx_ready}, 32'd1);

    // Instruction write: word 0x13 at address 0
    send_frame(8'h01, 32'h0000_0000, 32'h0000_0013, 1'b1);
    check("wi_rx_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
    tick(3);
    check("wi_pulses", inst_pulses, 32'd1);
    check("wi_a2", last_inst_a2, 32'h0000_0000);
    check("wi_wd2", last_inst_wd2, 32'h0000_0013);
    check("wi_data_pulses", data_pulses, 32'd0);
    check("wi_we2_after", {28'd0, inst_we2}, 32'd0);

    // Data write 0xDEADBEEF at 0x10, then read it back with stalls
    send_frame(8'h02, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    tick(3);
    check("wd_pulses", data_pulses, 32'd1);
    check("wd_a2", last_data_a2, 32'h0000_0010);
    check("wd_wd2", last_data_wd2, 32'hDEAD_BEEF);
    send_frame(8'h03, 32'h0000_0010, 32'd0, 1'b0);
    check("rd_rx_ready_busy", {31'd0, bus.rx_ready}, 32'd0);
    recv_byte("rd_b0", 8'hEF);
    recv_byte("rd_b1", 8'hBE);
    recv_byte("rd_b2", 8'hAD);
    recv_byte("rd_b3", 8'hDE);
    check("rd_tx_valid_done", {31'd0, bus.tx_valid}, 32'd0);
    check("rd_rx_ready_done", {31'd0, bus.rx_ready}, 32'd1);
    check("rd_no_we2", data_pulses + inst_pulses, 32'd2);

    // Instruction read of address 0
    send_frame(8'h04, 32'h0000_0000, 32'd0, 1'b0);
    recv_byte("ri_b0", 8'h13);
    recv_byte("ri_b1", 8'h00);
    recv_byte("ri_b2", 8'h00);
    recv_byte("ri_b3", 8'h00);

    // Run: memory commands must be dropped while the core runs
    send_byte(8'h05);
    check("run_core_rst", {31'd0, core_rst}, 32'd0);
    send_frame(8'h01, 32'h0000_0020, 32'hDDCC_BBAA, 1'b1);
    tick(3);
    check("run_no_inst_write", inst_pulses, 32'd1);
    check("run_no_data_write", data_pulses, 32'd1);
    send_byte(8'h06);
    check("halt_core_rst", {31'd0, core_rst}, 32'd1);

    // Reset in the middle of a data-write frame
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h30 : 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge CPU_CLK);
    CPU_RST = 1'b1;
    #1;
    check("mid_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    tick(2);
    check("mid_rst_no_write", data_pulses, 32'd1);
    send_frame(8'h02, 32'h0000_0030, 32'h1122_3344, 1'b1);
    tick(3);
    check("post_rst_pulses", data_pulses, 32'd2);
    check("post_rst_a2", last_data_a2, 32'h0000_0030);
    check("post_rst_wd2", last_data_wd2, 32'h1122_3344);
    send_frame(8'h03, 32'h0000_0030, 32'd0, 1'b0);
    recv_byte("post_rst_b0", 8'h44);
    recv_byte("post_rst_b1", 8'h33);
    recv_byte("post_rst_b2", 8'h22);
    recv_byte("post_rst_b3", 8'h11);

    // Unknown command is discarded; next frame runs normally
    ip = inst_pulses;
    dp = data_pulses;
    send_byte(8'h7F);
    tick(3);
    check("bad_cmd_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("bad_cmd_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("bad_cmd_no_access", inst_pulses + data_pulses, ip + dp);
    check("bad_cmd_core_rst", {31'd0, core_rst}, 32'd1);
    send_frame(8'h01, 32'h0000_0004, 32'h1234_5678, 1'b1);
    tick(3);
    check("after_bad_pulses", inst_pulses, ip + 1);
    check("after_bad_a2", last_inst_a2, 32'h0000_0004);
    check("after_bad_wd2", last_inst_wd2, 32'h1234_5678);
    check("after_bad_data_a2_hold", data_a2, 32'h0000_0030);

    check("strobe_shape", cross_errs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
